// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - shared ARP receive constants, field layout and FSM state type
package arp_pkg;

    localparam int ARP_WORDS = 7;
    localparam int WORD_W    = 32;
    localparam int HTYPE_W   = 16;
    localparam int PTYPE_W   = 16;
    localparam int HLEN_W    = 8;
    localparam int PLEN_W    = 8;
    localparam int OPER_W    = 16;
    localparam int HADDR_W   = 48;
    localparam int PADDR_W   = 32;

    localparam logic [HTYPE_W-1:0] HTYPE_ETH  = 16'h0001;
    localparam logic [PTYPE_W-1:0] PTYPE_IPV4 = 16'h0800;
    localparam logic [HLEN_W-1:0]  HLEN       = 8'd6;
    localparam logic [PLEN_W-1:0]  PLEN       = 8'd4;
    localparam logic [OPER_W-1:0]  OP_REQ     = 16'd1;
    localparam logic [OPER_W-1:0]  OP_REPLY   = 16'd2;

    // Member order matches the big-endian word order W0..W6 on the wire.
    typedef struct packed {
        logic [HTYPE_W-1:0] hdr_type;
        logic [PTYPE_W-1:0] proto_type;
        logic [HLEN_W-1:0]  hdr_addr_length;
        logic [PLEN_W-1:0]  pro_addr_length;
        logic [OPER_W-1:0]  operation;
        logic [HADDR_W-1:0] send_hdr_addr;
        logic [PADDR_W-1:0] send_ip_addr;
        logic [HADDR_W-1:0] target_hdr_addr;
        logic [PADDR_W-1:0] target_ip_addr;
    } arp_fields_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } arp_state_t;

endpackage

// File: rtl/arp_recv_if.sv
// rtl/arp_recv_if.sv - word stream in, parsed ARP fields out
interface arp_recv_if;
    import arp_pkg::*;

    logic [WORD_W-1:0]  input_receive;
    logic               input_valid;
    logic               input_sop;
    logic               input_hold;
    logic [HTYPE_W-1:0] hdr_type;
    logic [PTYPE_W-1:0] proto_type;
    logic [HLEN_W-1:0]  hdr_addr_length;
    logic [PLEN_W-1:0]  pro_addr_length;
    logic [OPER_W-1:0]  operation;
    logic [HADDR_W-1:0] send_hdr_addr;
    logic [PADDR_W-1:0] send_ip_addr;
    logic [HADDR_W-1:0] target_hdr_addr;
    logic [PADDR_W-1:0] target_ip_addr;
    logic               output_valid;
    logic               output_ready;
    logic               frame_error;

    modport slave (
        input  input_receive, input_valid, input_sop, output_ready,
        output input_hold, hdr_type, proto_type, hdr_addr_length, pro_addr_length,
               operation, send_hdr_addr, send_ip_addr, target_hdr_addr,
               target_ip_addr, output_valid, frame_error
    );

    modport master (
        output input_receive, input_valid, input_sop, output_ready,
        input  input_hold, hdr_type, proto_type, hdr_addr_length, pro_addr_length,
               operation, send_hdr_addr, send_ip_addr, target_hdr_addr,
               target_ip_addr, output_valid, frame_error
    );

endinterface

// File: rtl/arp_recv_check.sv
// rtl/arp_recv_check.sv - combinational Ethernet/IPv4 ARP header validity check
module arp_recv_check
    import arp_pkg::*;
(
    input  logic [HTYPE_W-1:0] hdr_type,
    input  logic [PTYPE_W-1:0] proto_type,
    input  logic [HLEN_W-1:0]  hdr_addr_length,
    input  logic [PLEN_W-1:0]  pro_addr_length,
    input  logic [OPER_W-1:0]  operation,
    output logic               ok
);

    assign ok = (hdr_type == HTYPE_ETH) &&
                (proto_type == PTYPE_IPV4) &&
                (hdr_addr_length == HLEN) &&
                (pro_addr_length == PLEN) &&
                ((operation == OP_REQ) || (operation == OP_REPLY));

endmodule

// File: rtl/arp_recv.sv
// rtl/arp_recv.sv - ARP packet receiver/parser; ARP_RECV_CHECK_EN adds header validation
module arp_recv
    import arp_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    arp_recv_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arp_state_t        state;
    logic [2:0]        idx;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [WORD_W-1:0] stage [0:5];
    arp_fields_t       fields;
    logic              accept;
    logic              check_ok;

    assign accept = bus.input_valid && !bus.input_hold;

`ifdef ARP_RECV_CHECK_EN
    // W0/W1 are already staged when W6 arrives, so the check sees them in time.
    arp_recv_check u_check (
        .hdr_type        (stage[0][31:16]),
        .proto_type      (stage[0][15:0]),
        .hdr_addr_length (stage[1][31:24]),
        .pro_addr_length (stage[1][23:16]),
        .operation       (stage[1][15:0]),
        .ok              (check_ok)
    );
`else
    assign check_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= 3'd0;
            tmo_cnt          <= '0;
            fields           <= '0;
            bus.output_valid <= 1'b0;
            bus.input_hold   <= 1'b0;
            bus.frame_error  <= 1'b0;
            for (int i = 0; i < 6; i++) stage[i] <= '0;
        end else begin
            bus.frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && bus.input_sop) begin
                        stage[0] <= bus.input_receive;
                        idx      <= 3'd1;
                        tmo_cnt  <= '0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        tmo_cnt <= '0;
                        if (bus.input_sop) begin
                            bus.frame_error <= 1'b1;
                            stage[0]        <= bus.input_receive;
                            idx             <= 3'd1;
                        end else if (idx == 3'd6) begin
                            idx <= 3'd0;
                            if (check_ok) begin
                                fields <= arp_fields_t'({stage[0], stage[1], stage[2], stage[3],
                                                         stage[4], stage[5], bus.input_receive});
                                bus.output_valid <= 1'b1;
                                bus.input_hold   <= 1'b1;
                                state            <= DONE;
                            end else begin
                                bus.frame_error <= 1'b1;
                                state           <= IDLE;
                            end
                        end else begin
                            stage[idx] <= bus.input_receive;
                            idx        <= idx + 3'd1;
                        end
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        bus.frame_error <= 1'b1;
                        tmo_cnt         <= '0;
                        idx             <= 3'd0;
                        state           <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.output_ready) begin
                        bus.output_valid <= 1'b0;
                        bus.input_hold   <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hdr_type        = fields.hdr_type;
    assign bus.proto_type      = fields.proto_type;
    assign bus.hdr_addr_length = fields.hdr_addr_length;
    assign bus.pro_addr_length = fields.pro_addr_length;
    assign bus.operation       = fields.operation;
    assign bus.send_hdr_addr   = fields.send_hdr_addr;
    assign bus.send_ip_addr    = fields.send_ip_addr;
    assign bus.target_hdr_addr = fields.target_hdr_addr;
    assign bus.target_ip_addr  = fields.target_ip_addr;

endmodule

// File: tb/tb_arp_recv.sv
// tb/tb_arp_recv.sv - scoreboard testbench for arp_recv
module tb_arp_recv;
    import arp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arp_recv_if bus ();

    arp_recv #(.TIMEOUT_CYC(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int fe_count = 0;
    int pops = 0;
    int pushes = 0;
    arp_fields_t exp_q[$];
    arp_fields_t act;
    arp_fields_t prev_fields;
    logic prev_pending = 1'b0;

    assign act = {bus.hdr_type, bus.proto_type, bus.hdr_addr_length, bus.pro_addr_length,
                  bus.operation, bus.send_hdr_addr, bus.send_ip_addr, bus.target_hdr_addr,
                  bus.target_ip_addr};

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: counts error pulses, pops the scoreboard on each handshake, checks stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pending <= 1'b0;
        end else begin
            if (bus.frame_error) fe_count++;
            if (prev_pending && bus.output_valid)
                check("fields_stable", act, prev_fields);
            if (bus.output_valid && bus.output_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("packet_fields", act, exp_q.pop_front());
                end
                pops++;
            end
            prev_pending <= bus.output_valid && !bus.output_ready;
            prev_fields  <= act;
        end
    end

    function automatic logic [31:0] word_of(input arp_fields_t p, input int i);
        logic [223:0] v;
        v = p;
        return v[223 - 32*i -: 32];
    endfunction

    function automatic arp_fields_t mk(input logic [7:0] hl, input logic [15:0] op,
                                       input logic [47:0] sha, input logic [31:0] spa,
                                       input logic [47:0] tha, input logic [31:0] tpa);
        arp_fields_t p;
        p.hdr_type        = 16'h0001;
        p.proto_type      = 16'h0800;
        p.hdr_addr_length = hl;
        p.pro_addr_length = 8'd4;
        p.operation       = op;
        p.send_hdr_addr   = sha;
        p.send_ip_addr    = spa;
        p.target_hdr_addr = tha;
        p.target_ip_addr  = tpa;
        return p;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic sop);
        bit done_w;
        done_w = 0;
        bus.input_receive = d;
        bus.input_valid   = 1'b1;
        bus.input_sop     = sop;
        for (int t = 0; t < 100 && !done_w; t++) begin
            @(negedge clk);
            if (!bus.input_hold) begin
                @(posedge clk);
                #1;
                done_w = 1;
            end
        end
        if (!done_w) check("send_word_accept", 0, 1);
        bus.input_valid = 1'b0;
        bus.input_sop   = 1'b0;
    endtask

    task automatic send_pkt(input arp_fields_t p, input int first, input int last);
        for (int i = first; i <= last; i++) send_word(word_of(p, i), i == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ovalid"}, bus.output_valid, 0);
        check({name, "_hold"}, bus.input_hold, 0);
        check({name, "_ferr"}, bus.frame_error, 0);
        check({name, "_fields"}, act, 0);
    endtask

    logic [31:0] nom_words [0:6];
    arp_fields_t nom, pa, pb, pc, pd, pe, pf, pg, ph, bad;
    int fe_base, fe_expected, got;

    initial begin
        bus.input_receive = '0;
        bus.input_valid   = 1'b0;
        bus.input_sop     = 1'b0;
        bus.output_ready  = 1'b1;
        fe_expected = 0;

        @(negedge clk);
        check_all_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Nominal: words written out by hand from the field values.
        nom_words[0] = 32'h00010800;
        nom_words[1] = 32'h06040001;
        nom_words[2] = 32'hF2AD9325;
        nom_words[3] = 32'hE67BF55F;
        nom_words[4] = 32'hD57D1122;
        nom_words[5] = 32'h33445566;
        nom_words[6] = 32'hC0A80001;
        nom = mk(8'd6, 16'd1, 48'hF2AD9325E67B, 32'hF55FD57D, 48'h112233445566, 32'hC0A80001);
        exp_q.push_back(nom); pushes++;
        for (int i = 0; i < 7; i++) send_word(nom_words[i], i == 0);
        check("nom_ovalid_latency", bus.output_valid, 1);
        check("nom_hold_high", bus.input_hold, 1);
        idle(1);
        check("nom_hold_one_cycle", bus.input_hold, 0);
        check("nom_ovalid_cleared", bus.output_valid, 0);
        idle(2);

        // Backpressure: second packet waits while the first is held.
        pa = mk(8'd6, 16'd2, 48'h0A0B0C0D0E0F, 32'h0A000001, 48'h102030405060, 32'h0A000002);
        pb = mk(8'd6, 16'd1, 48'hDEADBEEFCAFE, 32'hAC100001, 48'h000000000000, 32'hAC1000FE);
        bus.output_ready = 1'b0;
        exp_q.push_back(pa); pushes++;
        exp_q.push_back(pb); pushes++;
        send_pkt(pa, 0, 6);
        fork
            send_pkt(pb, 0, 6);
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("bp_hold", bus.input_hold, 1);
                    check("bp_ovalid", bus.output_valid, 1);
                end
                @(posedge clk);
                #1;
                bus.output_ready = 1'b1;
            end
        join
        idle(3);

        // Resync: sop at W3 position restarts the packet.
        pc = mk(8'd6, 16'd1, 48'h111111111111, 32'h01010101, 48'h222222222222, 32'h02020202);
        pd = mk(8'd6, 16'd2, 48'h333333333333, 32'h03030303, 48'h444444444444, 32'h04040404);
        fe_base = fe_count;
        exp_q.push_back(pd); pushes++;
        send_pkt(pc, 0, 2);
        send_pkt(pd, 0, 6);
        idle(3);
        check("resync_ferr_once", fe_count - fe_base, 1);
        fe_expected += 1;

        // Timeout after W2.
        pe = mk(8'd6, 16'd1, 48'h555555555555, 32'h05050505, 48'h666666666666, 32'h06060606);
        fe_base = fe_count;
        send_pkt(pe, 0, 2);
        got = 0;
        for (int n = 1; n <= 100 && got == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus.frame_error) got = n;
        end
        check("timeout_cycle", got, 64);
        check("timeout_state_idle", dut.state, IDLE);
        idle(2);
        check("timeout_ferr_once", fe_count - fe_base, 1);
        fe_expected += 1;
        pf = mk(8'd6, 16'd2, 48'h777777777777, 32'h07070707, 48'h888888888888, 32'h08080808);
        exp_q.push_back(pf); pushes++;
        send_pkt(pf, 0, 6);
        idle(3);

        // Bad hardware address length.
        bad = mk(8'd8, 16'd1, 48'h999999999999, 32'h09090909, 48'hAAAAAAAAAAAA, 32'h0A0A0A0A);
        fe_base = fe_count;
`ifdef ARP_RECV_CHECK_EN
        send_pkt(bad, 0, 6);
        for (int c = 0; c < 3; c++) begin
            check("badlen_no_ovalid", bus.output_valid, 0);
            idle(1);
        end
        check("badlen_ferr", fe_count - fe_base, 1);
        fe_expected += 1;
`else
        exp_q.push_back(bad); pushes++;
        send_pkt(bad, 0, 6);
        idle(3);
        check("badlen_no_ferr", fe_count - fe_base, 0);
`endif

        // Reset in the middle of a packet.
        pg = mk(8'd6, 16'd1, 48'hBBBBBBBBBBBB, 32'h0B0B0B0B, 48'hCCCCCCCCCCCC, 32'h0C0C0C0C);
        fe_base = fe_count;
        send_pkt(pg, 0, 4);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst_async");
        @(negedge clk);
        check_all_zero("midrst");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        ph = mk(8'd6, 16'd2, 48'hDDDDDDDDDDDD, 32'h0D0D0D0D, 48'hEEEEEEEEEEEE, 32'h0E0E0E0E);
        exp_q.push_back(ph); pushes++;
        send_pkt(ph, 0, 6);
        idle(4);
        check("midrst_no_ferr", fe_count - fe_base, 0);

        check("all_expected_consumed", exp_q.size(), 0);
        check("output_count", pops, pushes);
        check("total_ferr", fe_count, fe_expected);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/arp_recv.md
ARP_RECV -- requirements
Module: arp_recv

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum idle cycles between words of one packet before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port input_receive, input, 32, the packet word stream from the far-end arp_transm.
REQ-005 SHALL have port input_valid, input, 1, which qualifies input_receive.
REQ-006 SHALL have port input_sop, input, 1, marking word 0 of a packet; it is qualified by input_valid.
REQ-007 SHALL have port input_hold, output, 1; when high, the block refuses input words.
REQ-008 SHALL have parsed-field outputs hdr_type (16), proto_type (16), hdr_addr_length (8), pro_addr_length (8), operation (16), send_hdr_addr (48), send_ip_addr (32), target_hdr_addr (48), target_ip_addr (32).
REQ-009 SHALL have port output_valid, output, 1, meaning the parsed fields are complete and stable.
REQ-010 SHALL have port output_ready, input, 1, the consumer's acknowledge of output_valid.
REQ-011 SHALL have port frame_error, output, 1, a one-cycle pulse on an aborted or rejected packet.

Function
REQ-012 SHALL accept a word only on a cycle with input_valid=1 and input_hold=0.
REQ-013 SHALL use this 7-word big-endian layout:
- W0 = {hdr_type, proto_type}
- W1 = {hdr_addr_length, pro_addr_length, operation}
- W2 = send_hdr_addr[47:16]
- W3 = {send_hdr_addr[15:0], send_ip_addr[31:16]}
- W4 = {send_ip_addr[15:0], target_hdr_addr[47:32]}
- W5 = target_hdr_addr[31:0]
- W6 = target_ip_addr
REQ-014 SHALL implement FSM states IDLE, COLLECT and DONE, with a 3-bit word index 0..6.
REQ-015 IDLE transitions:
- An accepted word with input_sop=1 captures W0, sets index to 1 and moves to COLLECT.
- Accepted words without input_sop are discarded.
REQ-016 COLLECT transitions:
- Each accepted word is stored at the current index, and the index increments.
- Accepting W6 moves to DONE.
REQ-017 SHALL set output_valid high exactly 1 cycle after W6 is accepted, and hold it until output_ready is sampled high.
REQ-018 SHALL keep input_hold = (state == DONE), so no word is accepted in the cycle output_ready is sampled; the state returns to IDLE on the next edge.
REQ-019 SHALL keep the field outputs stable while output_valid=1; the next packet's words go to a staging register, which is copied to the outputs on entry to DONE.
REQ-020 On input_sop with an accepted word during COLLECT, SHALL abandon the partial packet, pulse frame_error, capture the new W0 and set index to 1.
REQ-021 SHALL count idle cycles in COLLECT, clearing the count on each accepted word; reaching TIMEOUT_CYC SHALL return the FSM to IDLE and pulse frame_error.
REQ-022 SHALL treat output_ready as don't-care outside DONE.

Reset
REQ-023 While rst_n=0, the FSM SHALL go to IDLE and the index and timeout count SHALL be 0.
REQ-024 While rst_n=0, output_valid, input_hold, frame_error and all field outputs SHALL be 0.
REQ-025 Reset during COLLECT or DONE SHALL discard the packet with no frame_error pulse.

Configuration
REQ-026 With ARP_RECV_CHECK_EN defined, the block SHALL check every packet on entry to DONE against:
- hdr_type == 16'h0001
- proto_type == 16'h0800
- hdr_addr_length == 8'd6
- pro_addr_length == 8'd4
- operation ∈ {1, 2}
REQ-027 With ARP_RECV_CHECK_EN defined, a failing packet SHALL pulse frame_error, return to IDLE, and leave output_valid low and the outputs unchanged.
REQ-028 Without ARP_RECV_CHECK_EN, the block SHALL perform no field check, and frame_error SHALL pulse only per REQ-020 and REQ-021.

Structure
REQ-029 Shared package arp_pkg SHALL hold:
- ARP_WORDS = 7
- all field widths
- the expected constants HTYPE_ETH = 16'h0001, PTYPE_IPV4 = 16'h0800, HLEN = 6, PLEN = 4, OP_REQ = 1, OP_REPLY = 2
- the FSM state typedef
REQ-030 The field check SHALL be one combinational sub-module, arp_recv_check, instantiated only under ARP_RECV_CHECK_EN.

Verification
REQ-031 Nominal packet: send 7 back-to-back words with hdr_type=0x0001, proto_type=0x0800, lengths 6/4, op=1, send_hdr_addr=48'hF2AD9325E67B, send_ip_addr=32'hF55FD57D and output_ready=1. Required: output_valid high 1 cycle after W6, every field matches, and input_hold is high for 1 cycle.
REQ-032 Backpressure: hold output_ready=0 for 10 cycles while driving a second packet. Required: input_hold=1 and the fields stay stable throughout; after ready, the second packet is received intact.
REQ-033 Resync: assert input_sop at W3 of a packet, then send a full packet. Required: frame_error pulses once, and only the second packet produces output_valid.
REQ-034 Timeout: stop input after W2 for TIMEOUT_CYC=64 cycles. Required: frame_error pulses at cycle 64, and the FSM is in IDLE.
REQ-035 With ARP_RECV_CHECK_EN defined, send hdr_addr_length=8. Required: frame_error pulses, output_valid stays 0. Without the macro, the same packet is output normally.
REQ-036 Assert rst_n=0 mid-COLLECT (after W4), then send a full packet. Required: all outputs are 0 during reset, there is no frame_error, and the next packet parses correctly.
